// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the request arbiter family.
// The arbiter FSM enum and the index-width rule live here so every block sizes grant_idx the same way.
package arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // A single requester still gets a one-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational rotating-priority picker.
// Rotates req so that ptr lands on bit 0, takes the lowest set bit, then un-rotates it.
module rr_pick
   import arb_pkg::*;
#(
   parameter int N = 4,
   localparam int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx,
   output logic [N-1:0]  onehot
);

   localparam int PW = IW + 1;

   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   req_rot;
   logic [PW-1:0]  pos;

   always_comb begin
      req_dbl = {req, req} >> ptr;
      req_rot = req_dbl[N-1:0];
      found   = 1'b0;
      pos     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            found = 1'b1;
            pos   = PW'(k);
         end
      end
      // ptr < N and offset < N, so one conditional subtract wraps for any N.
      pos = pos + {1'b0, ptr};
      if (pos >= PW'(N)) begin
         pos = pos - PW'(N);
      end
      idx    = found ? pos[IW-1:0] : '0;
      onehot = '0;
      for (int j = 0; j < N; j++) begin
         onehot[j] = found && (idx == IW'(j));
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// N-way arbiter with registered grant, hold-until-ack and round-robin or fixed priority.
// state | meaning
// IDLE  | no grant outstanding, outputs all zero, waiting for any req
// BUSY  | one requester holds the grant until it pulses ack
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int N  = 4,
   parameter bit RR = 1'b1,
   localparam int IW = idx_width(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          ack,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_valid
);

   arb_state_e    state, state_next;
   logic [IW-1:0] ptr, ptr_next, ptr_ack, pick_ptr, pick_idx;
   logic [N-1:0]  pick_onehot;
   logic          pick_found;
   logic          load, clear;

   // Holder moves to lowest priority on ack; wrap is explicit for non-power-of-2 N.
   always_comb begin
      ptr_ack = '0;
      if (RR && (grant_idx != IW'(N - 1))) begin
         ptr_ack = grant_idx + IW'(1);
      end
      pick_ptr = (state == BUSY) ? ptr_ack : ptr;
   end

   rr_pick #(.N(N)) u_pick (
      .req    (req),
      .ptr    (pick_ptr),
      .found  (pick_found),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      load       = 1'b0;
      clear      = 1'b0;
      unique case (state)
         IDLE: begin
            if (pick_found) begin
               load       = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (ack) begin
               ptr_next = ptr_ack;
               if (pick_found) begin
                  load = 1'b1;
               end else begin
                  clear      = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: begin
            clear      = 1'b1;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         grant       <= '0;
         grant_idx   <= '0;
         grant_valid <= 1'b0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
         if (load) begin
            grant       <= pick_onehot;
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
         end else if (clear) begin
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
         end
      end
   end

   a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
      grant_valid |-> (grant == (N'(1) << grant_idx)));

   a_idle_zero: assert property (@(posedge clk) disable iff (rst)
      !grant_valid |-> ((grant == '0) && (grant_idx == '0)));

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Parametrised N-way request arbiter with registered one-hot and binary grant outputs, grant hold until acknowledge, and selectable round-robin or fixed-priority mode. It is the sequential successor to the combinational priority encoder. It sits between N requesters and one shared resource (bus, memory port, output channel). Per grant, one requester owns the resource until it pulses `ack`.

## Interface
- `N`, default 4: number of requesters, ≥1.
- `RR`, default 1: 1 selects round-robin (rotating priority); 0 selects fixed priority, where the lowest index wins.
- `IW`, derived: `N>1 ? $clog2(N) : 1`.

- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req`  in  N: request vector, one bit per requester, level-sensitive.
- `ack`  in  1: the current grant holder is done; single-cycle pulse.
- `grant`  out  N: one-hot grant, registered.
- `grant_idx`  out  IW: binary index of the granted requester, registered.
- `grant_valid`  out  1: a grant is active.

## Operation
- State machine with 2 states.
  - `IDLE`: no grant.
  - `BUSY`: grant held.
- Priority pointer `ptr` (IW bits):
  - `ptr` names the highest-priority index.
  - Search order is `ptr`, `ptr+1`, … `N-1`, 0, … wrapping mod N.
  - The first index with `req[i]=1` wins.
- `RR=0`: `ptr` is constant 0.
- IDLE:
  - If `|req`, the winner is chosen using the current `ptr`.
  - The next cycle enters BUSY with `grant`, `grant_idx` and `grant_valid=1` loaded.
  - Otherwise stay in IDLE.
- BUSY:
  - Outputs are held stable regardless of `req` changes. The holder dropping its `req` does not revoke the grant.
  - On `ack` with `RR=1`, `ptr_next = (grant_idx+1) mod N`.
  - On `ack`, the winner is re-evaluated over `req` sampled in the ack cycle, using `ptr_next`. The holder's own request is included, at lowest priority in RR mode.
  - If there is a winner, the new grant is loaded next cycle and the block stays in BUSY (back-to-back).
  - If there is none, go to IDLE with all outputs 0.
- `ack` in IDLE is ignored.
- `N=1`:
  - `grant_idx` is always 0.
  - The state machine still applies.
- Invariants:
  - `grant` is one-hot when `grant_valid=1` and all-zero otherwise.
  - `grant_idx` matches `grant`.
  - `grant_idx` is 0 in IDLE.
  - `grant_valid` is never high with a `grant` bit whose index is ≥N.

## Timing
- Reset values (the cycle after `rst` is sampled high):
  - `grant=0`, `grant_idx=0`, `grant_valid=0`.
  - `ptr=0`.
  - State IDLE.
- `rst` mid-BUSY aborts the grant unconditionally. No `ack` is required.
- `rst` has priority over `ack` and `req`.
- Latency from `req` rising in IDLE to `grant_valid`: 1 cycle.
- Latency from `ack` to the next grant: 1 cycle. `grant_valid` stays high across the handover and `grant` changes on the same edge.
- Latency from `ack` with no pending requests to `grant_valid` low: 1 cycle.
- Maximum throughput: one grant per cycle when `ack` is asserted every cycle.
- `ptr` wrap: `grant_idx=N-1` followed by `ack` gives `ptr=0`. For non-power-of-2 N, this wrap is explicit, not a natural overflow.
- Simultaneous `ack` and change of `req` in the same cycle: arbitration uses the `req` value of that cycle.

## Structure
- Package `arb_pkg` holds the `arb_state_e` enum typedef (`IDLE`, `BUSY`).
- Sub-module `rr_pick`:
  - Purely combinational.
  - Parameter `N`.
  - Inputs: `req`, `ptr`.
  - Outputs: `found`, `idx`, `onehot`.
  - Implemented as a rotate → lowest-set-bit → un-rotate, or an equivalent loop.
- `rr_arbiter` holds the state register, `ptr`, the output registers and the `ack` handling.

## Test plan
All scenarios use `N=4`, `RR=1` unless stated otherwise.
- Reset:
  - Drive `rst=1` for 2 cycles with `req=4'b1111`.
  - Required: `grant=0000`, `grant_idx=0`, `grant_valid=0` throughout, and the first grant goes to idx0 one cycle after `rst` drops.
- Single requester:
  - Drive `req=0001`.
  - Required: `grant=0001`, `idx=0`, `valid=1` next cycle.
  - With `req` held, `ack` must give idx0 again back-to-back, with valid never dropping.
- Rotation:
  - Drive `req=0110` from reset.
  - Required: grant idx1; after `ack`, idx2; after the next `ack` (`req` still `0110`), idx1.
- Fairness:
  - Drive `req=1111` and pulse `ack` every cycle.
  - Required: `grant_idx` sequence 0,1,2,3,0, which checks the wrap.
- Hold and release:
  - In BUSY (idx2), drop `req` to `0000` with no `ack` for 5 cycles.
  - Required: the grant stays at `0100`.
  - Then `ack`: `grant_valid=0` and `grant=0000` the next cycle.
- Fixed priority (`RR=0`):
  - Drive `req=1010` with repeated `ack`.
  - Required: always idx1.
  - Then assert `rst` mid-BUSY: outputs are 0 the next cycle.
